// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and serial line levels,
// common to uart_tx and uart_rx.
`timescale 1ns/1ps
package uart_pkg;

  // Frame sequencing states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Serial line levels
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WIDTH data bits MSB first, even parity, stop.
// One serial bit per rising clk_baud edge; all outputs are registers.
// Define UART_TX_TWO_STOP_EN for two stop bits (frame WIDTH+4 cycles);
// otherwise one stop bit (frame WIDTH+3 cycles).
`timescale 1ns/1ps
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_baud,
  input  logic             rst,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic             tx_out,
  output logic             tx_busy
);

`ifdef UART_TX_TWO_STOP_EN
  localparam int unsigned STOP_CYCLES = 2;
`else
  localparam int unsigned STOP_CYCLES = 1;
`endif

  localparam int unsigned    CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
  localparam logic           STOP_LAST = 1'(STOP_CYCLES - 1);

  uart_state_t      state;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic             parity_bit;
  logic             stop_cnt;

  // Frame FSM; each output register holds the level for the coming bit period
  always_ff @(posedge clk_baud or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      stop_cnt   <= 1'b0;
      tx_out     <= IDLE_LEVEL;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shift_reg  <= tx_data;
            parity_bit <= ^tx_data;
            state      <= START;
            tx_out     <= START_LEVEL;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
          end
        end
        START: begin
          state     <= DATA;
          tx_out    <= shift_reg[WIDTH-1];
          shift_reg <= shift_reg << 1;
          bit_cnt   <= '0;
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            state   <= PARITY;
            tx_out  <= parity_bit;
            bit_cnt <= '0;
          end else begin
            tx_out    <= shift_reg[WIDTH-1];
            shift_reg <= shift_reg << 1;
            bit_cnt   <= bit_cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          state    <= STOP;
          tx_out   <= STOP_LEVEL;
          stop_cnt <= 1'b0;
        end
        STOP: begin
          if (stop_cnt == STOP_LAST) begin
            state    <= IDLE;
            tx_out   <= IDLE_LEVEL;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            stop_cnt <= 1'b0;
          end else begin
            tx_out   <= STOP_LEVEL;
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          tx_out   <= IDLE_LEVEL;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: bytes are queued at acceptance and compared
// against frames decoded from tx_out.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int unsigned WIDTH = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int unsigned STOP_CYCLES = 2;
`else
  localparam int unsigned STOP_CYCLES = 1;
`endif
  localparam int unsigned FRAME_LEN = WIDTH + 2 + STOP_CYCLES;

  logic             clk_baud = 1'b0;
  logic             rst      = 1'b0;
  logic             tx_valid = 1'b0;
  logic [WIDTH-1:0] tx_data  = '0;
  logic             tx_ready;
  logic             tx_out;
  logic             tx_busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [WIDTH-1:0] exp_q[$];

  bit               in_frame = 1'b0;
  int unsigned      idle_run = 0;
  int unsigned      last_gap = 0;
  int unsigned      frames   = 0;

  uart_tx #(.WIDTH(WIDTH)) dut (
    .clk_baud (clk_baud),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx_out   (tx_out),
    .tx_busy  (tx_busy)
  );

  always #5 clk_baud = ~clk_baud;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference even parity by counting ones
  function automatic logic ref_parity(input logic [WIDTH-1:0] d);
    int ones = 0;
    for (int i = 0; i < WIDTH; i++) ones += int'(d[i]);
    return 1'(ones % 2);
  endfunction

  // Decode frames from tx_out, sampled on the falling edge
  task automatic monitor();
    int unsigned      bit_idx = 0;
    logic [WIDTH-1:0] rx_data = '0;
    logic             rx_par  = 1'b0;
    logic [WIDTH-1:0] exp_d;
    forever begin
      @(negedge clk_baud);
      if (!rst) begin
        in_frame = 1'b0;
        idle_run = 0;
      end else if (!in_frame) begin
        if (tx_out === 1'b0) begin
          in_frame = 1'b1;
          bit_idx  = 1;
          last_gap = idle_run;
          rx_data  = '0;
        end else begin
          idle_run++;
        end
      end else begin
        if (bit_idx <= WIDTH) rx_data = {rx_data[WIDTH-2:0], tx_out};
        else if (bit_idx == WIDTH + 1) rx_par = tx_out;
        else check_eq("stop_bit", 32'(tx_out), 32'd1);
        if (bit_idx == FRAME_LEN - 1) begin
          frames++;
          check_eq("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_d = exp_q.pop_front();
            check_eq("frame_data", 32'(rx_data), 32'(exp_d));
            check_eq("frame_parity", 32'(rx_par), 32'(ref_parity(exp_d)));
          end
          in_frame = 1'b0;
          idle_run = 0;
        end else begin
          bit_idx++;
        end
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tx_ready && n < 100) begin
      @(negedge clk_baud);
      n++;
    end
    check_eq("ready_wait", 32'(tx_ready), 32'd1);
  endtask

  // Present one byte for a single accepting edge; returns 1ns after that edge
  task automatic send(input logic [WIDTH-1:0] d);
    @(negedge clk_baud);
    wait_ready();
    tx_data  = d;
    tx_valid = 1'b1;
    exp_q.push_back(d);
    @(posedge clk_baud);
    #1;
    tx_valid = 1'b0;
    tx_data  = WIDTH'($urandom);
    check_eq("busy_after_accept", 32'(tx_busy), 32'd1);
  endtask

  // Count rising edges from acceptance until tx_ready returns
  task automatic time_ready(input string tag);
    int n = 0;
    while (!tx_ready && n < 64) begin
      @(posedge clk_baud);
      #1;
      n++;
    end
    check_eq(tag, 32'(n), 32'(FRAME_LEN));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < 400) begin
      @(negedge clk_baud);
      n++;
    end
    check_eq("drain", 32'(n < 400), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned f0;
    fork
      monitor();
    join_none

    // Reset values
    repeat (2) @(posedge clk_baud);
    #1;
    check_eq("rst_tx_out", 32'(tx_out), 32'd1);
    check_eq("rst_tx_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_tx_busy", 32'(tx_busy), 32'd0);
    @(negedge clk_baud);
    rst = 1'b1;

    // 0xA5 frame, then line stays high
    send(8'hA5);
    time_ready("a5_ready_latency");
    wait_idle();
    repeat (3) begin
      @(negedge clk_baud);
      check_eq("idle_high", 32'(tx_out), 32'd1);
    end

    // 0x01: parity 1 and ready latency
    send(8'h01);
    time_ready("01_ready_latency");
    wait_idle();

    // Back-to-back with tx_valid held high
    f0 = frames;
    @(negedge clk_baud);
    wait_ready();
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    exp_q.push_back(8'h3C);
    @(posedge clk_baud);
    #1;
    tx_data = 8'hC3;
    exp_q.push_back(8'hC3);
    begin
      int n = 0;
      while (!tx_ready && n < 64) begin
        @(posedge clk_baud);
        #1;
        n++;
      end
      check_eq("b2b_first_len", 32'(n), 32'(FRAME_LEN));
    end
    @(posedge clk_baud);
    #1;
    tx_valid = 1'b0;
    check_eq("b2b_second_accept", 32'(tx_busy), 32'd1);
    wait_idle();
    check_eq("b2b_frames", 32'(frames - f0), 32'd2);
    check_eq("b2b_idle_gap", 32'(last_gap), 32'd1);

    // Data changes and valid pulses while busy are ignored
    f0 = frames;
    send(8'hB4);
    for (int i = 0; i < int'(FRAME_LEN) - 3; i++) begin
      @(negedge clk_baud);
      tx_data  = WIDTH'($urandom);
      tx_valid = i[0];
      check_eq("busy_mid_frame", 32'(tx_busy), 32'd1);
    end
    @(negedge clk_baud);
    tx_valid = 1'b0;
    wait_idle();
    repeat (2 * FRAME_LEN) @(negedge clk_baud);
    check_eq("no_extra_frame", 32'(frames - f0), 32'd1);

    // Reset during data bit 3, then a clean 0x5A frame
    send(8'h69);
    repeat (4) @(posedge clk_baud);
    #2;
    rst = 1'b0;
    #1;
    check_eq("midrst_tx_out", 32'(tx_out), 32'd1);
    check_eq("midrst_tx_ready", 32'(tx_ready), 32'd1);
    check_eq("midrst_tx_busy", 32'(tx_busy), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk_baud);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    exp_q.push_back(8'h5A);
    rst = 1'b1;
    @(posedge clk_baud);
    #1;
    tx_valid = 1'b0;
    check_eq("accept_after_rst", 32'(tx_busy), 32'd1);
    time_ready("5a_ready_latency");
    wait_idle();

    // All ones: parity 0, full stop period
    send(8'hFF);
    time_ready("ff_ready_latency");
    wait_idle();

    // A few random bytes
    for (int k = 0; k < 4; k++) begin
      send(WIDTH'($urandom));
      time_ready("rand_ready_latency");
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of data bits per frame.
REQ-002 SHALL have port clk_baud  input  1  bit-rate clock; one serial bit per rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port tx_valid  input  1  source holds a byte for transmission.
REQ-005 SHALL have port tx_data  input  WIDTH  byte to transmit; sampled only on acceptance.
REQ-006 SHALL have port tx_ready  output  1  block can accept a byte this cycle.
REQ-007 SHALL have port tx_out  output  1  serial line to the downstream receiver; idle high.
REQ-008 SHALL have port tx_busy  output  1  frame in progress.

Function
REQ-009 SHALL use states IDLE, START, DATA, PARITY, STOP, clocked on posedge clk_baud.
REQ-010 SHALL accept a byte at a rising edge where tx_valid=1 and tx_ready=1, latching tx_data into an internal shift register.
REQ-011 SHALL drive tx_ready=1 only in IDLE, as a registered output; tx_valid in other states is ignored and the byte is not consumed.
REQ-012 SHALL move IDLE->START on acceptance, then drive tx_out=0 for exactly one cycle.
REQ-013 SHALL move START->DATA and send WIDTH data bits MSB first, one per cycle, using a bit counter that runs 0..WIDTH-1 and then clears.
REQ-014 SHALL move DATA->PARITY after the last data bit, then drive one even-parity bit equal to the XOR of the latched byte.
REQ-015 SHALL move PARITY->STOP, drive tx_out=1 for the stop period, then return to IDLE.
REQ-016 SHALL make a frame with one stop bit occupy WIDTH+3 cycles: start + WIDTH + parity + stop.
REQ-017 SHALL keep tx_out=1 in IDLE, so back-to-back frames are separated by at least one idle-high cycle.
REQ-018 SHALL ignore tx_data changes after acceptance; the frame in flight uses the latched value.
REQ-019 SHALL drive tx_busy=1 in every state except IDLE.
REQ-020 SHALL drive all outputs from registers, with no combinational path from input to output.

Reset
REQ-021 SHALL, on rst low at any time including mid-frame, force IDLE immediately and asynchronously, with tx_out=1, tx_ready=1, tx_busy=0.
REQ-022 SHALL, on reset, clear the shift register and bit counter to 0 and abandon any partial frame; the partial frame is not resumed.
REQ-023 SHALL, on rst release, make the first acceptance possible at the next rising clk_baud edge.

Configuration
REQ-024 SHALL, with macro UART_TX_TWO_STOP_EN defined, hold STOP for two cycles, giving a WIDTH+4 cycle frame.
REQ-025 SHALL, without UART_TX_TWO_STOP_EN, hold STOP for one cycle, giving a WIDTH+3 cycle frame.

Structure
REQ-026 SHALL place the state encoding (IDLE, START, DATA, PARITY, STOP) and the frame constants (start level 0, stop/idle level 1) in shared package uart_pkg, for reuse by uart_rx.
REQ-027 SHALL be a single flat module with no sub-module; the parity generator is one XOR reduction.

Verification
REQ-028 SHALL check that tx_data=0xA5 accepted gives tx_out 0,1,0,1,0,0,1,0,1,0(parity),1(stop), then stays high.
REQ-029 SHALL check that tx_data=0x01 gives parity bit 1 and that tx_ready returns 1 exactly WIDTH+3 cycles after acceptance.
REQ-030 SHALL check that tx_valid held high with 0x3C then 0xC3 gives two complete frames with exactly one idle-high cycle between them.
REQ-031 SHALL check that changing tx_data during a frame, and pulsing tx_valid while busy, leaves the frame unchanged and consumes no extra byte.
REQ-032 SHALL check that rst low during DATA bit 3 sets tx_out=1 and tx_ready=1 immediately, and that the next accepted 0x5A transmits a correct full frame.
REQ-033 SHALL check, with UART_TX_TWO_STOP_EN defined, that a 0xFF frame has parity 0, two stop cycles, and a WIDTH+4 cycle length.
